// File: rtl/dkong3_subrom_arb.sv
// dkong3_subrom_arb: time-slots one shared 16 KB single-port memory between two sub-CPU ROM
// read ports and a byte-wide download writer.
//
// A phase counter restarts at 0 on the clock after each CPU strobe. It saturates at 11.
// Phase 2 is the CPU-1 read slot and phase 4 is the CPU-2 read slot. Read data arrives one
// clock after the slot and is registered one clock later, so O_DOn updates two clocks after
// the slot address is driven. Download bytes go straight to the port outside read slots.
// A byte that arrives during a slot is held in a one-entry buffer until the next free cycle.
//
// Ports:
//   I_SUBCLK                 clock
//   I_RESET                  synchronous active-high reset
//   I_CPU_CE                 sub-CPU clock-enable strobe
//   I_REQ1/2, I_ADDR1/2      ROM select and 13-bit byte address per sub CPU
//   I_DL_WR/ADDR/DATA        download write strobe, 14-bit address, data byte
//   O_MEM_ADDR/WE/DI         shared memory port
//   I_MEM_DO                 memory read data, valid one clock after the address
//   O_DO1/2, O_VALID1/2      per-CPU read data (zero when deselected) and update pulse
//   O_DL_OVR                 sticky lost-download-byte flag
module dkong3_subrom_arb (
    input  logic        I_SUBCLK,
    input  logic        I_RESET,
    input  logic        I_CPU_CE,
    input  logic        I_REQ1,
    input  logic        I_REQ2,
    input  logic [12:0] I_ADDR1,
    input  logic [12:0] I_ADDR2,
    input  logic        I_DL_WR,
    input  logic [13:0] I_DL_ADDR,
    input  logic [7:0]  I_DL_DATA,
    output logic [13:0] O_MEM_ADDR,
    output logic        O_MEM_WE,
    output logic [7:0]  O_MEM_DI,
    input  logic [7:0]  I_MEM_DO,
    output logic [7:0]  O_DO1,
    output logic [7:0]  O_DO2,
    output logic        O_VALID1,
    output logic        O_VALID2,
    output logic        O_DL_OVR
);

    typedef enum logic {WbIdle, WbPend} wb_state_e;

    localparam logic [3:0] PhaseLast = 4'd11;

    logic [3:0]  phase_q, phase_d;
    wb_state_e   wb_state_q, wb_state_d;
    logic [13:0] wb_addr_q, wb_addr_d;
    logic [7:0]  wb_data_q, wb_data_d;
    logic [13:0] addr_q;
    logic [7:0]  di_q;
    logic        ovr_q, ovr_d;
    logic        rd1_q, rd2_q;
    logic        req1_q, req2_q;
    logic [7:0]  do1_q, do2_q;
    logic        valid1_q, valid2_q;

    logic slot1, slot2, slot;

    assign slot1 = (phase_q == 4'd2);
    assign slot2 = (phase_q == 4'd4);
    assign slot  = slot1 | slot2;

    always_comb begin
        phase_d = phase_q;
        if (I_CPU_CE) begin
            phase_d = 4'd0;
        end else if (phase_q >= PhaseLast) begin
            phase_d = PhaseLast;
        end else begin
            phase_d = phase_q + 4'd1;
        end
    end

    // Memory port mux and write-buffer next state. Read slots always win the port.
    always_comb begin
        O_MEM_ADDR = addr_q;
        O_MEM_DI   = di_q;
        O_MEM_WE   = 1'b0;
        wb_state_d = wb_state_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        ovr_d      = ovr_q;

        if (slot1) begin
            O_MEM_ADDR = {1'b0, I_ADDR1};
        end else if (slot2) begin
            O_MEM_ADDR = {1'b1, I_ADDR2};
        end

        unique case (wb_state_q)
            WbIdle: begin
                if (I_DL_WR) begin
                    if (slot) begin
                        wb_addr_d  = I_DL_ADDR;
                        wb_data_d  = I_DL_DATA;
                        wb_state_d = WbPend;
                    end else begin
                        O_MEM_WE   = 1'b1;
                        O_MEM_ADDR = I_DL_ADDR;
                        O_MEM_DI   = I_DL_DATA;
                    end
                end
            end
            WbPend: begin
                if (slot) begin
                    // Buffer is full and the port is busy: the new byte is lost.
                    if (I_DL_WR) begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    O_MEM_WE   = 1'b1;
                    O_MEM_ADDR = wb_addr_q;
                    O_MEM_DI   = wb_data_q;
                    if (I_DL_WR) begin
                        // Drain the old byte now and queue the new one behind it.
                        wb_addr_d = I_DL_ADDR;
                        wb_data_d = I_DL_DATA;
                    end else begin
                        wb_state_d = WbIdle;
                    end
                end
            end
            default: wb_state_d = WbIdle;
        endcase

        // Reset suppresses any write in the reset cycle and parks the port at zero.
        if (I_RESET) begin
            O_MEM_WE   = 1'b0;
            O_MEM_ADDR = 14'd0;
            O_MEM_DI   = 8'd0;
        end
    end

    always_ff @(posedge I_SUBCLK) begin
        if (I_RESET) begin
            phase_q    <= PhaseLast;
            wb_state_q <= WbIdle;
            wb_addr_q  <= 14'd0;
            wb_data_q  <= 8'd0;
            addr_q     <= 14'd0;
            di_q       <= 8'd0;
            ovr_q      <= 1'b0;
            rd1_q      <= 1'b0;
            rd2_q      <= 1'b0;
            req1_q     <= 1'b0;
            req2_q     <= 1'b0;
            do1_q      <= 8'd0;
            do2_q      <= 8'd0;
            valid1_q   <= 1'b0;
            valid2_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wb_state_q <= wb_state_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            addr_q     <= O_MEM_ADDR;
            di_q       <= O_MEM_DI;
            ovr_q      <= ovr_d;
            // rdN_q marks "memory data for CPU N is on I_MEM_DO this cycle".
            rd1_q      <= slot1;
            rd2_q      <= slot2;
            if (slot1) begin
                req1_q <= I_REQ1;
            end
            if (slot2) begin
                req2_q <= I_REQ2;
            end
            valid1_q   <= rd1_q;
            valid2_q   <= rd2_q;
            if (rd1_q) begin
                do1_q <= req1_q ? I_MEM_DO : 8'h00;
            end
            if (rd2_q) begin
                do2_q <= req2_q ? I_MEM_DO : 8'h00;
            end
        end
    end

    assign O_DO1    = do1_q;
    assign O_DO2    = do2_q;
    assign O_VALID1 = valid1_q;
    assign O_VALID2 = valid2_q;
    assign O_DL_OVR = ovr_q;

endmodule
